hall_sample_scheduler: RTL and testbench
========================================

Name: hall_sample_scheduler

Overview:
Sequences the per-motor hall counters: at a fixed sample rate it snapshots every motor's free-running hall count and computes the signed per-period delta with one shared subtractor. It publishes a double-buffered delta bank to the SPI register file through a req/ack read port. It also flags invalid hall codes and stalled motors. Sits between the hall counter array and the SPI slave.

Parameters:
NUM_MOTORS, 5, number of hall counters serviced (1..8)
COUNT_WIDTH, 8, width of each hall count and delta
PERIOD_CYCLES, 18432, clk cycles per sample period (1 kHz at 18.432 MHz); must be >= NUM_MOTORS+4
STALL_PERIODS, 16, consecutive zero-delta snapshots before stall is flagged

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  run sampling; 0 holds the FSM in IDLE
counts  in  NUM_MOTORS*COUNT_WIDTH  concatenated hall counts, motor 0 in LSBs
hall_raw  in  NUM_MOTORS*3  raw hall inputs, already synchronised, motor 0 in LSBs
clear_faults  in  1  one-cycle pulse clears hall_fault
rd_req  in  1  read request pulse
rd_idx  in  3  motor index to read
rd_ack  out  1  one-cycle read acknowledge
rd_delta  out  COUNT_WIDTH  signed delta of the published bank
snap_seq  out  8  published snapshot sequence number
sample_tick  out  1  one-cycle pulse on each CAPTURE
hall_fault  out  NUM_MOTORS  sticky flag: code 000 or 111 seen
stalled  out  NUM_MOTORS  motor stalled while enabled

Behaviour:
- Reset: all outputs 0; period counter 0; previous-count regs 0; stall counters 0; both banks 0; FSM in IDLE.
- FSM states:
  - IDLE -> WAIT when enable=1.
  - WAIT: period counter counts to PERIOD_CYCLES-1, then -> CAPTURE.
  - CAPTURE (1 cycle): latch all counts; sample_tick=1.
  - DIFF: one motor per cycle, NUM_MOTORS cycles; working[i] = cap[i] - prev[i] mod 2^COUNT_WIDTH (two's complement, wraps naturally); prev[i] <= cap[i].
  - PUBLISH (1 cycle): working bank -> published bank; snap_seq += 1 (wraps 255->0) -> WAIT.
- Period counter restarts at CAPTURE, so the sample spacing is exactly PERIOD_CYCLES.
- enable=0 in any state -> IDLE next cycle; partial DIFF results are discarded. The published bank, snap_seq and prev are held.
- First snapshot after reset yields delta = count - 0.
- Read port:
  - rd_req sampled each cycle; rd_ack and rd_delta are registered 1 cycle later.
  - rd_idx >= NUM_MOTORS returns 0 with ack.
  - rd_req coincident with PUBLISH returns the pre-publish value.
  - A read never stalls; back-to-back requests are acked every cycle.
- hall_fault[i] is set on any cycle where hall_raw[i] is 000 or 111. A clear_faults pulse clears it; set wins over clear in the same cycle.
- Stall counter per motor:
  - In PUBLISH, a zero delta increments the counter (saturating at STALL_PERIODS); a nonzero delta resets it to 0.
  - stalled[i] = (counter == STALL_PERIODS).
  - enable=0 clears all stall counters and stalled.
- Async reset mid-DIFF: immediate return to reset values; no partial publish.

Optional Feature:
HALL_SAMPLE_ACCUM_EN:
- With the macro: adds output rd_accum (16, signed) and per-motor 16-bit accumulators updated in PUBLISH by the sign-extended delta, wrapping modulo 2^16. rd_accum is returned with the same timing as rd_delta; rd_idx out of range returns 0.
- Without the macro: no port, no accumulators; behaviour is otherwise identical.

Decomposition:
- Shared package hall_pkg: hall step codes STEP_1..STEP_6, invalid codes 3'b000/3'b111, FSM state encoding (IDLE, WAIT, CAPTURE, DIFF, PUBLISH), default widths.
- Sub-module hall_sample_timer: period counter with restart and enable; emits the CAPTURE strobe.

Test Plan:
1. Reset, enable=1, counts all 0x10 constant, PERIOD_CYCLES=32 -> sample_tick every 32 cycles; first publish gives delta 0x10, second gives 0x00; snap_seq 1 then 2.
2. Motor 2 count goes 0xFE -> 0x03 between samples -> rd_idx=2 returns rd_delta=0x05; 0x03 -> 0xFB gives 0xF8 (-8).
3. Reads with rd_req every cycle, rd_idx 0..7 -> rd_ack each following cycle; idx 5..7 return 0; read in the PUBLISH cycle returns the old delta.
4. hall_raw motor 0 = 3'b111 for 1 cycle -> hall_fault[0]=1 and sticky; clear_faults coincident with a second 111 -> stays 1; clear alone -> 0.
5. Motor 1 constant for 16 snapshots -> stalled[1]=1 at the 16th PUBLISH; one nonzero delta -> 0; enable=0 -> all stalled 0 and FSM IDLE.
6. With HALL_SAMPLE_ACCUM_EN: deltas +100 x 400 on motor 3 -> rd_accum = 40000 mod 65536 = 0x9C40; async rst mid-DIFF -> all outputs 0 at once.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared definitions for the hall sampling path: hall step codes, invalid
// codes, scheduler FSM encoding and default widths.
package hall_pkg;

    localparam int DEFAULT_NUM_MOTORS    = 5;
    localparam int DEFAULT_COUNT_WIDTH   = 8;
    localparam int DEFAULT_PERIOD_CYCLES = 18432;
    localparam int DEFAULT_STALL_PERIODS = 16;
    localparam int ACCUM_WIDTH           = 16;

    // Valid six-step commutation sequence.
    localparam logic [2:0] STEP_1 = 3'b001;
    localparam logic [2:0] STEP_2 = 3'b011;
    localparam logic [2:0] STEP_3 = 3'b010;
    localparam logic [2:0] STEP_4 = 3'b110;
    localparam logic [2:0] STEP_5 = 3'b100;
    localparam logic [2:0] STEP_6 = 3'b101;

    localparam logic [2:0] HALL_INVALID_LO = 3'b000;
    localparam logic [2:0] HALL_INVALID_HI = 3'b111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        CAPTURE = 3'd2,
        DIFF    = 3'd3,
        PUBLISH = 3'd4
    } state_t;

    function automatic logic hall_code_invalid(input logic [2:0] code);
        return (code == HALL_INVALID_LO) || (code == HALL_INVALID_HI);
    endfunction

endpackage

// File: rtl/hall_sample_timer.sv
// Sample period counter: runs modulo PERIOD_CYCLES while enabled and strobes
// on the last cycle of each period, so CAPTURE lands exactly one period apart.
module hall_sample_timer #(
    parameter int PERIOD_CYCLES = 18432
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic strobe
);

    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Wrapping on the strobe cycle restarts the period at CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign strobe = run && (cnt == LAST);

endmodule

// File: rtl/hall_sample_scheduler.sv
// Periodic hall-count snapshot, shared-subtractor delta, double-buffered
// delta bank with req/ack read port, hall fault and stall flags.
// Optional macro HALL_SAMPLE_ACCUM_EN adds per-motor 16-bit accumulators and rd_accum.
//
// Read handshake: rd_req is sampled on every clock; the cycle after a sampled
// request rd_ack pulses for one cycle with rd_delta (and rd_accum) valid.
// There is no ready side: a read is never refused or delayed.
module hall_sample_scheduler
    import hall_pkg::*;
#(
    parameter int NUM_MOTORS    = DEFAULT_NUM_MOTORS,
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
    parameter int PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
    parameter int STALL_PERIODS = DEFAULT_STALL_PERIODS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [NUM_MOTORS*COUNT_WIDTH-1:0] counts,
    input  logic [NUM_MOTORS*3-1:0]           hall_raw,
    input  logic                              clear_faults,
    input  logic                              rd_req,
    input  logic [2:0]                        rd_idx,
    output logic                              rd_ack,
    output logic [COUNT_WIDTH-1:0]            rd_delta,
    output logic [7:0]                        snap_seq,
    output logic                              sample_tick,
    output logic [NUM_MOTORS-1:0]             hall_fault,
    output logic [NUM_MOTORS-1:0]             stalled,
`ifdef HALL_SAMPLE_ACCUM_EN
    output logic [ACCUM_WIDTH-1:0]            rd_accum,
`endif
    output logic [2:0]                        fsm_state
);

    localparam int SW = $clog2(STALL_PERIODS + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_PERIODS);
    localparam logic [2:0] LAST_IDX = 3'(NUM_MOTORS - 1);

    state_t state;
    logic [2:0] diff_idx;
    logic period_done;
    logic rd_in_range;

    logic [COUNT_WIDTH-1:0] cap  [NUM_MOTORS];
    logic [COUNT_WIDTH-1:0] prev [NUM_MOTORS];
    logic [COUNT_WIDTH-1:0] work [NUM_MOTORS];
    logic [COUNT_WIDTH-1:0] pub  [NUM_MOTORS];
    logic [SW-1:0]          stall_cnt [NUM_MOTORS];

    assign fsm_state   = state;
    assign rd_in_range = ({1'b0, rd_idx} < 4'(NUM_MOTORS));

    hall_sample_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (enable && (state != IDLE)),
        .strobe(period_done)
    );

    // prev is committed together with the bank in PUBLISH, so an aborted
    // DIFF leaves the reference counts exactly as they were.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            diff_idx    <= '0;
            sample_tick <= 1'b0;
            snap_seq    <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                cap[i]  <= '0;
                prev[i] <= '0;
                work[i] <= '0;
                pub[i]  <= '0;
            end
        end else begin
            sample_tick <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                diff_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (period_done) begin
                            state       <= CAPTURE;
                            sample_tick <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        for (int i = 0; i < NUM_MOTORS; i++) begin
                            cap[i] <= counts[i*COUNT_WIDTH +: COUNT_WIDTH];
                        end
                        diff_idx <= '0;
                        state    <= DIFF;
                    end
                    DIFF: begin
                        work[diff_idx] <= cap[diff_idx] - prev[diff_idx];
                        if (diff_idx == LAST_IDX) begin
                            state <= PUBLISH;
                        end else begin
                            diff_idx <= diff_idx + 3'd1;
                        end
                    end
                    PUBLISH: begin
                        for (int i = 0; i < NUM_MOTORS; i++) begin
                            pub[i]  <= work[i];
                            prev[i] <= cap[i];
                        end
                        snap_seq <= snap_seq + 8'd1;
                        state    <= WAIT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                stall_cnt[i] <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                stall_cnt[i] <= '0;
            end
        end else if (state == PUBLISH) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (work[i] != '0) begin
                    stall_cnt[i] <= '0;
                end else if (stall_cnt[i] != STALL_MAX) begin
                    stall_cnt[i] <= stall_cnt[i] + SW'(1);
                end
            end
        end
    end

    always_comb begin
        stalled = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            stalled[i] = (stall_cnt[i] == STALL_MAX);
        end
    end

    // A new invalid code wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hall_fault <= '0;
        end else begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                hall_fault[i] <= (hall_fault[i] && !clear_faults)
                                 || hall_code_invalid(hall_raw[i*3 +: 3]);
            end
        end
    end

    // The bank swaps on the same edge that samples a PUBLISH-cycle request,
    // so such a read returns the pre-publish value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack   <= 1'b0;
            rd_delta <= '0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_delta <= rd_in_range ? pub[rd_idx] : '0;
            end
        end
    end

`ifdef HALL_SAMPLE_ACCUM_EN
    logic [ACCUM_WIDTH-1:0] accum [NUM_MOTORS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_accum <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                accum[i] <= '0;
            end
        end else begin
            if (enable && (state == PUBLISH)) begin
                for (int i = 0; i < NUM_MOTORS; i++) begin
                    accum[i] <= accum[i] + ACCUM_WIDTH'($signed(work[i]));
                end
            end
            if (rd_req) begin
                rd_accum <= rd_in_range ? accum[rd_idx] : '0;
            end
        end
    end
`else
    // Delta-only build: no accumulator state.
`endif

endmodule

// File: tb/tb_hall_sample_scheduler.sv
// Directed bench for hall_sample_scheduler with a 32-cycle sample period.
// Define HALL_SAMPLE_ACCUM_EN to also exercise the accumulator read-back.
module tb_hall_sample_scheduler;
    import hall_pkg::*;

    localparam int N = 5;
    localparam int W = 8;
    localparam int P = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N*W-1:0] counts;
    logic [N*3-1:0] hall_raw;
    logic           clear_faults;
    logic           rd_req;
    logic [2:0]     rd_idx;
    logic           rd_ack;
    logic [W-1:0]   rd_delta;
    logic [7:0]     snap_seq;
    logic           sample_tick;
    logic [N-1:0]   hall_fault;
    logic [N-1:0]   stalled;
    logic [2:0]     fsm_state;
`ifdef HALL_SAMPLE_ACCUM_EN
    logic [15:0]    rd_accum;
`endif

    int tests_run = 0;
    int fails = 0;
    logic [7:0] exp_seq;

    hall_sample_scheduler #(
        .NUM_MOTORS(N), .COUNT_WIDTH(W), .PERIOD_CYCLES(P), .STALL_PERIODS(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .counts(counts), .hall_raw(hall_raw),
        .clear_faults(clear_faults), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_ack(rd_ack), .rd_delta(rd_delta), .snap_seq(snap_seq),
        .sample_tick(sample_tick), .hall_fault(hall_fault), .stalled(stalled),
`ifdef HALL_SAMPLE_ACCUM_EN
        .rd_accum(rd_accum),
`endif
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_count(input int m, input logic [7:0] v);
        counts[m*W +: W] = v;
    endtask

    // Called at a negedge; advances at least one cycle, returns on the negedge in state st.
    task automatic wait_state(input logic [2:0] st, input int bound);
        int n = 0;
        @(negedge clk);
        while (fsm_state !== st && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (fsm_state !== st) begin
            tests_run++;
            fails++;
            $display("FAIL wait_state: state %0d required %0d after %0d cycles", fsm_state, st, n);
        end
    endtask

    task automatic wait_publish();
        wait_state(PUBLISH, 100);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic do_read(input logic [2:0] idx);
        rd_req = 1'b1;
        rd_idx = idx;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; clear_faults = 1'b0; rd_req = 1'b0; rd_idx = '0;
        counts = {N{8'h10}};
        hall_raw = {N{STEP_1}};
        exp_seq = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rd_ack, rd_delta, snap_seq, sample_tick, hall_fault, stalled} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ack=%b delta=%h seq=%h tick=%b fault=%b stall=%b, want all 0",
                     rd_ack, rd_delta, snap_seq, sample_tick, hall_fault, stalled);
        end
`ifdef HALL_SAMPLE_ACCUM_EN
        tests_run++;
        if (rd_accum !== 16'h0) begin
            fails++;
            $display("FAIL reset_accum: got %h want 0000", rd_accum);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (fsm_state !== IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE);
        end
    endtask

    task automatic test_period();
        int n = 0;
        enable = 1'b1;
        while (!sample_tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 33) begin
            fails++;
            $display("FAIL first_tick: got %0d cycles want 33", n);
        end
        @(negedge clk);
        tests_run++;
        if (sample_tick !== 1'b0) begin
            fails++;
            $display("FAIL tick_width: got %b want 0", sample_tick);
        end
        n = 1;
        while (!sample_tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== P) begin
            fails++;
            $display("FAIL tick_spacing: got %0d want %0d", n, P);
        end
        exp_seq = 8'd1;
        tests_run++;
        if (snap_seq !== exp_seq) begin
            fails++;
            $display("FAIL seq_first: got %0d want %0d", snap_seq, exp_seq);
        end
        do_read(3'd0);
        tests_run++;
        if (rd_ack !== 1'b1 || rd_delta !== 8'h10) begin
            fails++;
            $display("FAIL first_delta: got ack=%b delta=%h want ack=1 delta=10", rd_ack, rd_delta);
        end
        wait_publish();
        @(negedge clk);
        do_read(3'd4);
        tests_run++;
        if (snap_seq !== 8'd2 || rd_delta !== 8'h00) begin
            fails++;
            $display("FAIL second_delta: got seq=%0d delta=%h want seq=2 delta=00", snap_seq, rd_delta);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] vals [3] = '{8'hFE, 8'h03, 8'hFB};
        logic [7:0] exps [3] = '{8'hEE, 8'h05, 8'hF8};
        for (int k = 0; k < 3; k++) begin
            set_count(2, vals[k]);
            wait_publish();
            @(negedge clk);
            do_read(3'd2);
            tests_run++;
            if (rd_delta !== exps[k]) begin
                fails++;
                $display("FAIL wrap_delta_%0d: got %h want %h", k, rd_delta, exps[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tab [8] = '{8'h05, 8'h07, 8'h09, 8'hFE, 8'h20, 8'h00, 8'h00, 8'h00};
        set_count(0, 8'h15); set_count(1, 8'h17); set_count(2, 8'h04);
        set_count(3, 8'h0E); set_count(4, 8'h30);
        wait_publish();
        @(negedge clk);
        rd_req = 1'b1;
        rd_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests_run++;
            if (rd_ack !== 1'b1 || rd_delta !== exp_tab[k]) begin
                fails++;
                $display("FAIL b2b_read_%0d: got ack=%b delta=%h want ack=1 delta=%h",
                         k, rd_ack, rd_delta, exp_tab[k]);
            end
            if (k < 7) rd_idx = 3'(k + 1);
            else rd_req = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (rd_ack !== 1'b0) begin
            fails++;
            $display("FAIL ack_drop: got %b want 0", rd_ack);
        end
        set_count(0, 8'h25);
        wait_publish();
        do_read(3'd0);
        tests_run++;
        if (rd_delta !== 8'h05) begin
            fails++;
            $display("FAIL read_in_publish: got %h want 05", rd_delta);
        end
        do_read(3'd0);
        tests_run++;
        if (rd_delta !== 8'h10 || snap_seq !== exp_seq) begin
            fails++;
            $display("FAIL read_after_publish: got delta=%h seq=%0d want delta=10 seq=%0d",
                     rd_delta, snap_seq, exp_seq);
        end
    endtask

    task automatic test_faults();
        hall_raw[2:0] = 3'b111;
        @(negedge clk);
        hall_raw[2:0] = STEP_1;
        tests_run++;
        if (hall_fault !== 5'b00001) begin
            fails++;
            $display("FAIL fault_set: got %b want 00001", hall_fault);
        end
        @(negedge clk);
        tests_run++;
        if (hall_fault !== 5'b00001) begin
            fails++;
            $display("FAIL fault_sticky: got %b want 00001", hall_fault);
        end
        hall_raw[2:0] = 3'b111;
        clear_faults = 1'b1;
        @(negedge clk);
        hall_raw[2:0] = STEP_1;
        clear_faults = 1'b0;
        tests_run++;
        if (hall_fault !== 5'b00001) begin
            fails++;
            $display("FAIL fault_set_wins: got %b want 00001", hall_fault);
        end
        clear_faults = 1'b1;
        @(negedge clk);
        clear_faults = 1'b0;
        tests_run++;
        if (hall_fault !== 5'b00000) begin
            fails++;
            $display("FAIL fault_clear: got %b want 00000", hall_fault);
        end
        hall_raw[14:12] = 3'b000;
        @(negedge clk);
        hall_raw[14:12] = STEP_4;
        tests_run++;
        if (hall_fault !== 5'b10000) begin
            fails++;
            $display("FAIL fault_code000: got %b want 10000", hall_fault);
        end
        clear_faults = 1'b1;
        @(negedge clk);
        clear_faults = 1'b0;
    endtask

    task automatic test_stall();
        set_count(1, 8'h40);
        wait_publish();
        @(negedge clk);
        tests_run++;
        if (stalled[1] !== 1'b0) begin
            fails++;
            $display("FAIL stall_nonzero_start: got %b want 0", stalled[1]);
        end
        for (int k = 1; k <= 16; k++) begin
            wait_publish();
            @(negedge clk);
            tests_run++;
            if (stalled[1] !== (k == 16)) begin
                fails++;
                $display("FAIL stall_count_%0d: got %b want %b", k, stalled[1], (k == 16));
            end
        end
        set_count(1, 8'h41);
        wait_publish();
        @(negedge clk);
        tests_run++;
        if (stalled !== 5'b11101) begin
            fails++;
            $display("FAIL stall_release: got %b want 11101", stalled);
        end
        enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (stalled !== 5'b00000 || fsm_state !== IDLE) begin
            fails++;
            $display("FAIL disable: got stall=%b state=%0d want stall=00000 state=%0d",
                     stalled, fsm_state, IDLE);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (snap_seq !== exp_seq) begin
            fails++;
            $display("FAIL seq_held: got %0d want %0d", snap_seq, exp_seq);
        end
    endtask

    task automatic test_abort();
        enable = 1'b1;
        set_count(0, 8'h30);
        wait_state(DIFF, 100);
        enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (fsm_state !== IDLE) begin
            fails++;
            $display("FAIL abort_state: got %0d want %0d", fsm_state, IDLE);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (snap_seq !== exp_seq) begin
            fails++;
            $display("FAIL abort_no_publish: got %0d want %0d", snap_seq, exp_seq);
        end
    endtask

    task automatic test_reset_mid_diff();
        enable = 1'b1;
        hall_raw[2:0] = 3'b000;
        @(negedge clk);
        hall_raw[2:0] = STEP_1;
        wait_state(DIFF, 100);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({snap_seq, hall_fault, stalled, sample_tick, rd_ack} !== '0 || fsm_state !== IDLE) begin
            fails++;
            $display("FAIL async_reset: got seq=%0d fault=%b stall=%b tick=%b ack=%b state=%0d want all 0",
                     snap_seq, hall_fault, stalled, sample_tick, rd_ack, fsm_state);
        end
        counts = '0;
        set_count(0, 8'h21);
        exp_seq = '0;
        @(negedge clk);
        rst = 1'b0;
        wait_publish();
        @(negedge clk);
        do_read(3'd0);
        tests_run++;
        if (snap_seq !== 8'd1 || rd_delta !== 8'h21) begin
            fails++;
            $display("FAIL post_reset_delta: got seq=%0d delta=%h want seq=1 delta=21", snap_seq, rd_delta);
        end
    endtask

`ifdef HALL_SAMPLE_ACCUM_EN
    task automatic test_accum();
        for (int k = 0; k < 400; k++) begin
            set_count(3, counts[3*W +: W] + 8'd100);
            wait_publish();
        end
        @(negedge clk);
        do_read(3'd3);
        tests_run++;
        if (rd_accum !== 16'h9C40 || rd_delta !== 8'h64) begin
            fails++;
            $display("FAIL accum_m3: got accum=%h delta=%h want accum=9c40 delta=64", rd_accum, rd_delta);
        end
        do_read(3'd0);
        tests_run++;
        if (rd_accum !== 16'h0021) begin
            fails++;
            $display("FAIL accum_m0: got %h want 0021", rd_accum);
        end
        do_read(3'd7);
        tests_run++;
        if (rd_accum !== 16'h0000) begin
            fails++;
            $display("FAIL accum_range: got %h want 0000", rd_accum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_period();
        test_wrap();
        test_back_to_back();
        test_faults();
        test_stall();
        test_abort();
        test_reset_mid_diff();
`ifdef HALL_SAMPLE_ACCUM_EN
        test_accum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
